pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central hazard and sequencing controller for the five-stage CPU pipeline. Every cycle it decides whether each pipeline register (IF/ID, ID/EX, EX/ME, ME/WB) and the PC advance, hold or flush. It handles three cases: load-use stalls, branch/jump redirects resolved in the ME stage, and variable-latency data-memory accesses using a request/acknowledge handshake. It also keeps a timeout watchdog on memory accesses and two performance counters.

## Interface
- TIMEOUT, 255: maximum MEM_WAIT cycles before the access is abandoned; range 1..65535.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_useRs1, id_useRs2  in  1 each  the ID instruction actually reads rs1 / rs2.
- ex_readMem  in  3  load type in EX; nonzero means a load.
- ex_rd  in  5  destination register in EX.
- me_readMem  in  3  load type in ME; nonzero means a load.
- me_writeMem  in  2  store type in ME; nonzero means a store.
- me_redirect  in  1  taken branch or jump resolved in ME.
- dmem_ack  in  1  data memory has completed the current access.
- perf_clr  in  1  synchronous clear of both performance counters.
- dmem_req  out  1  data-memory access request.
- pc_stall  out  1  PC holds its value.
- if_id_stall, id_ex_stall, ex_me_stall  out  1 each  register holds its value.
- if_id_flush, id_ex_flush, ex_me_flush, me_wb_flush  out  1 each  register loads a bubble (all zeros).
- mem_err  out  1  sticky flag: a memory access timed out.
- stall_cycles  out  32  count of cycles in which pc_stall was asserted.
- flush_events  out  32  count of redirects.

## Operation
- mem_access = (me_readMem != 0) | (me_writeMem != 0).
- load_use = (ex_readMem != 0) & (ex_rd != 0) & ((id_useRs1 & id_rs1 == ex_rd) | (id_useRs2 & id_rs2 == ex_rd)).
- The FSM has two states: RUN and MEM_WAIT. Reset state is RUN. The 16-bit wait counter resets to 0.
- dmem_req = mem_access in RUN; dmem_req = 1 throughout MEM_WAIT.
- RUN, priority order (highest first):
  1. mem_access & !dmem_ack: go to MEM_WAIT. Assert pc_stall, if_id_stall, id_ex_stall, ex_me_stall and me_wb_flush. Clear the wait counter.
  2. me_redirect: assert if_id_flush, id_ex_flush and ex_me_flush. PC is not stalled, so it loads the target. flush_events increments.
  3. load_use: assert pc_stall, if_id_stall and id_ex_flush.
  4. Otherwise all control outputs are 0.
- mem_access & dmem_ack in the same cycle is a zero-wait access: stay in RUN and fall through to rules 2-4.
- MEM_WAIT, dmem_ack = 0: all four stall outputs and me_wb_flush stay 1, and the wait counter increments.
- MEM_WAIT, dmem_ack = 1: return to RUN. All stall and flush outputs are 0 this cycle, so the pipeline advances and ME/WB captures the result.
- MEM_WAIT timeout: when the wait counter equals TIMEOUT-1 with no ack, set mem_err and return to RUN.
  - That cycle keeps me_wb_flush = 1, so the abandoned access never writes back.
  - The stall outputs are 0 that cycle.
- mem_err clears only on reset.
- me_redirect and load_use are ignored while in MEM_WAIT; the pipeline is frozen, so they are re-evaluated after the exit.
- A load with ex_rd = x0 never triggers a load-use stall.
- Simultaneous me_redirect and load_use: the redirect wins and no stall is asserted, because the ID instruction is flushed anyway.
- Counters:
  - stall_cycles increments in every cycle where pc_stall = 1.
  - flush_events increments on every rule-2 cycle.
  - Both wrap at 2^32.
  - perf_clr zeroes both counters on the next edge and has priority over an increment in the same cycle.

## Timing
- All control outputs are combinational from the current state and this cycle's inputs. The consuming registers act on the same rising edge.
- State, wait counter, mem_err and the perf counters update on the rising edge of clk.
- Reset while rst = 0: state RUN, wait counter 0, mem_err 0, stall_cycles 0, flush_events 0.
- Reset mid-MEM_WAIT abandons the access immediately; dmem_req falls as soon as the ME inputs are zero.
- An access acknowledged after N wait cycles costs exactly N stall cycles.
- A load-use hazard costs exactly 1 stall cycle.
- A redirect costs 3 flushed slots and 0 stall cycles.

## Test plan
- Load-use stall:
  - Stimulus: ex_readMem=3'b010, ex_rd=5, id_useRs1=1, id_rs1=5.
  - Response: pc_stall=if_id_stall=id_ex_flush=1 for 1 cycle; stall_cycles=1. Repeating with ex_rd=0 gives all outputs 0.
- Zero-wait access:
  - Stimulus: me_writeMem=2'b01, dmem_ack=1.
  - Response: dmem_req=1, all stall outputs 0, state stays RUN.
- 3-cycle memory wait:
  - Stimulus: me_readMem=3'b001, dmem_ack low for 3 cycles and then high.
  - Response: 3 cycles with all stalls and me_wb_flush = 1, then 1 cycle with all outputs 0 except dmem_req; stall_cycles=3.
- Redirect priority:
  - Stimulus: me_redirect=1 together with a load_use condition.
  - Response: if_id_flush=id_ex_flush=ex_me_flush=1, pc_stall=0, flush_events increments by 1.
- Timeout:
  - Stimulus: TIMEOUT=4, load in ME, dmem_ack held 0.
  - Response: exit to RUN after the 4th cycle, mem_err=1 and held, me_wb_flush=1 on the exit cycle.
- Reset mid-wait and counter clear:
  - Stimulus: drop rst during MEM_WAIT.
  - Response: all registers return to their reset values immediately. perf_clr together with pc_stall=1 gives stall_cycles=0 on the next edge.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: load-use stalls,
// ME-stage redirects, data-memory wait handshake with timeout, and perf counters.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_useRs1,
  input  logic        id_useRs2,
  input  logic [2:0]  ex_readMem,
  input  logic [4:0]  ex_rd,
  input  logic [2:0]  me_readMem,
  input  logic [1:0]  me_writeMem,
  input  logic        me_redirect,
  input  logic        dmem_ack,
  input  logic        perf_clr,
  output logic        dmem_req,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        ex_me_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_me_flush,
  output logic        me_wb_flush,
  output logic        mem_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic               mem_access;
  logic               load_use;
  logic               err_set;
  logic               flush_evt;

  assign mem_access = (me_readMem != 3'd0) | (me_writeMem != 2'd0);
  assign load_use   = (ex_readMem != 3'd0) & (ex_rd != 5'd0) &
                      ((id_useRs1 & (id_rs1 == ex_rd)) | (id_useRs2 & (id_rs2 == ex_rd)));

  // State register and wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state and combinational pipeline controls
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    dmem_req    = 1'b0;
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    id_ex_stall = 1'b0;
    ex_me_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_me_flush = 1'b0;
    me_wb_flush = 1'b0;
    err_set     = 1'b0;
    flush_evt   = 1'b0;
    case (state_q)
      RUN: begin
        dmem_req = mem_access;
        if (mem_access && !dmem_ack) begin
          state_d     = MEM_WAIT;
          wait_d      = '0;
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_stall = 1'b1;
          ex_me_stall = 1'b1;
          me_wb_flush = 1'b1;
        end else if (me_redirect) begin
          // Redirect beats load-use: the stalled ID instruction is flushed anyway
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          ex_me_flush = 1'b1;
          flush_evt   = 1'b1;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_d = RUN;
        end else if (wait_q == WAIT_LAST) begin
          // Abandon the access; keep ME/WB bubbled so nothing writes back
          state_d     = RUN;
          me_wb_flush = 1'b1;
          err_set     = 1'b1;
        end else begin
          wait_d      = wait_q + CNT_W'(1);
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_stall = 1'b1;
          ex_me_stall = 1'b1;
          me_wb_flush = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_err <= 1'b0;
    end else if (err_set) begin
      mem_err <= 1'b1;
    end
  end

  // Performance counters; clear wins over increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (pc_stall)  stall_cycles <= stall_cycles + 32'd1;
      if (flush_evt) flush_events <= flush_events + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table plus hand-written
// sequences for memory wait, timeout, reset mid-wait and counter clear.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_useRs1, id_useRs2;
  logic [2:0]  ex_readMem;
  logic [4:0]  ex_rd;
  logic [2:0]  me_readMem;
  logic [1:0]  me_writeMem;
  logic        me_redirect, dmem_ack, perf_clr;
  logic        dmem_req, pc_stall, if_id_stall, id_ex_stall, ex_me_stall;
  logic        if_id_flush, id_ex_flush, ex_me_flush, me_wb_flush;
  logic        mem_err;
  logic [31:0] stall_cycles, flush_events;

  pipeline_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_useRs1(id_useRs1), .id_useRs2(id_useRs2),
    .ex_readMem(ex_readMem), .ex_rd(ex_rd), .me_readMem(me_readMem),
    .me_writeMem(me_writeMem), .me_redirect(me_redirect), .dmem_ack(dmem_ack),
    .perf_clr(perf_clr), .dmem_req(dmem_req), .pc_stall(pc_stall),
    .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall), .ex_me_stall(ex_me_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_me_flush(ex_me_flush),
    .me_wb_flush(me_wb_flush), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  // exp bit order: req, pc_stall, if_id/id_ex/ex_me stall, if_id/id_ex/ex_me/me_wb flush
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [2:0] exrm;
    logic [4:0] exrd;
    logic [2:0] merm;
    logic [1:0] mewm;
    logic       redir;
    logic       ack;
    logic [8:0] exp;
  } vec_t;

  localparam logic [8:0] E_IDLE  = 9'b0_0000_0000;
  localparam logic [8:0] E_LU    = 9'b0_1100_0100;
  localparam logic [8:0] E_REQ   = 9'b1_0000_0000;
  localparam logic [8:0] E_REQLU = 9'b1_1100_0100;
  localparam logic [8:0] E_REDIR = 9'b0_0000_1110;
  localparam logic [8:0] E_WAIT  = 9'b1_1111_0001;
  localparam logic [8:0] E_TMO   = 9'b1_0000_0001;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [8:0]  exp_q[$];
  logic [31:0] exp_stall = 0;
  logic [31:0] exp_flush = 0;
  logic        exp_err = 1'b0;
  vec_t        tbl[10];

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic use1, input logic use2,
                              input logic [2:0] exrm, input logic [4:0] exrd,
                              input logic [2:0] merm, input logic [1:0] mewm,
                              input logic redir, input logic ack, input logic [8:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2;
    v.exrm = exrm; v.exrd = exrd; v.merm = merm; v.mewm = mewm;
    v.redir = redir; v.ack = ack; v.exp = exp;
    return v;
  endfunction

  function automatic logic [8:0] outs();
    return {dmem_req, pc_stall, if_id_stall, id_ex_stall, ex_me_stall,
            if_id_flush, id_ex_flush, ex_me_flush, me_wb_flush};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_useRs1 = v.use1; id_useRs2 = v.use2;
    ex_readMem = v.exrm; ex_rd = v.exrd; me_readMem = v.merm; me_writeMem = v.mewm;
    me_redirect = v.redir; dmem_ack = v.ack;
  endtask

  // One clock: drive, push expectation, compare at negedge, then check registers
  task automatic step(input string name, input vec_t v, input logic clr);
    logic [8:0] e;
    apply(v);
    perf_clr = clr;
    exp_q.push_back(v.exp);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk({name, "/queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({name, "/ctrl"}, 32'(outs()), 32'(e));
      if (clr) begin
        exp_stall = 0;
        exp_flush = 0;
      end else begin
        if (e[7]) exp_stall = exp_stall + 32'd1;
        if (e[3]) exp_flush = exp_flush + 32'd1;
      end
    end
    @(posedge clk);
    #1;
    perf_clr = 1'b0;
    chk({name, "/stall_cycles"}, stall_cycles, exp_stall);
    chk({name, "/flush_events"}, flush_events, exp_flush);
    chk({name, "/mem_err"}, 32'(mem_err), 32'(exp_err));
  endtask

  vec_t idle, ld_wait, ld_ack, lu_v;

  initial begin
    rst = 1'b0;
    perf_clr = 1'b0;
    idle    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_IDLE);
    ld_wait = mk(0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, E_WAIT);
    ld_ack  = mk(0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 1, E_REQ);
    lu_v    = mk(5, 0, 1, 0, 3'b010, 5, 0, 0, 0, 0, E_LU);
    apply(idle);

    tbl[0] = idle;
    tbl[1] = lu_v;
    tbl[2] = mk(0, 0, 1, 0, 3'b010, 0, 0, 0, 0, 0, E_IDLE);
    tbl[3] = mk(1, 7, 0, 1, 3'b100, 7, 0, 0, 0, 0, E_LU);
    tbl[4] = mk(5, 0, 0, 0, 3'b010, 5, 0, 0, 0, 0, E_IDLE);
    tbl[5] = mk(5, 0, 1, 0, 3'b000, 5, 0, 0, 0, 0, E_IDLE);
    tbl[6] = mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 1, E_REQ);
    tbl[7] = mk(5, 0, 1, 0, 3'b010, 5, 0, 0, 1, 0, E_REDIR);
    tbl[8] = mk(5, 0, 1, 0, 3'b010, 5, 3'b001, 0, 0, 1, E_REQLU);
    tbl[9] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, E_REDIR);

    #3;
    chk("reset/stall_cycles", stall_cycles, 32'd0);
    chk("reset/flush_events", flush_events, 32'd0);
    chk("reset/mem_err", 32'(mem_err), 32'd0);
    chk("reset/ctrl", 32'(outs()), 32'd0);
    #20 rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) step($sformatf("vec%0d", i), tbl[i], 1'b0);

    // 3-cycle wait; redirect/load-use inside the wait must be ignored
    step("wait0", ld_wait, 1'b0);
    step("wait1", mk(5, 0, 1, 0, 3'b010, 5, 3'b001, 0, 1, 0, E_WAIT), 1'b0);
    step("wait2", ld_wait, 1'b0);
    step("wait_ack", ld_ack, 1'b0);
    step("wait_after", idle, 1'b0);

    // Timeout with TIMEOUT=4: entry cycle, 3 waiting cycles, then the abandon cycle
    step("tmo_enter", ld_wait, 1'b0);
    step("tmo_w0", ld_wait, 1'b0);
    step("tmo_w1", ld_wait, 1'b0);
    step("tmo_w2", ld_wait, 1'b0);
    exp_err = 1'b1;
    step("tmo_exit", mk(0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, E_TMO), 1'b0);
    step("tmo_hold", idle, 1'b0);

    // Asynchronous reset in the middle of a wait
    step("rst_enter", ld_wait, 1'b0);
    step("rst_w0", ld_wait, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("rstmid/mem_err", 32'(mem_err), 32'd0);
    chk("rstmid/stall_cycles", stall_cycles, 32'd0);
    chk("rstmid/ctrl_run", 32'(outs()), 32'(E_WAIT));
    apply(idle);
    #1;
    chk("rstmid/req_low", 32'(dmem_req), 32'd0);
    exp_stall = 0;
    exp_flush = 0;
    exp_err   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("post_rst_idle", idle, 1'b0);
    step("post_rst_redir", tbl[9], 1'b0);

    // perf_clr beats a same-cycle increment
    step("clr_lu", lu_v, 1'b1);
    step("lu_after_clr", lu_v, 1'b0);
    step("final_idle", idle, 1'b0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
